// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between decode, the ALU issue stage and writeback.
// master: the side that offers operands and consumes results.
// slave:  the issue stage itself.
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_A;
    logic [DATA_WIDTH-1:0] in_B;
    logic [2:0]            in_ALUop;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_Result;
    logic                  out_Zero;
    logic                  out_CarryOut;
    logic                  out_Overflow;
    logic                  out_illegal;

    modport master (
        output in_valid, in_A, in_B, in_ALUop, out_ready,
        input  in_ready, out_valid, out_Result, out_Zero, out_CarryOut,
               out_Overflow, out_illegal
    );

    modport slave (
        input  in_valid, in_A, in_B, in_ALUop, out_ready,
        output in_ready, out_valid, out_Result, out_Zero, out_CarryOut,
               out_Overflow, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Registered ALU execute stage with a single-entry operand skid buffer.
// Optional feature: define ALU_STICKY_FLAGS_EN to build sticky overflow and
// carry-out flags; without it the sticky outputs are tied to 0.
//
// state | meaning
// EMPTY | output register invalid
// BUSY  | output register valid, skid empty
// FULL  | output register and skid both valid, input blocked

// Combinational ALU. CarryOut is the carry for ADD and the borrow for SUB;
// Overflow is signed overflow for ADD/SUB. Logic ops and SLT report no flags
// other than Zero.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUop,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             CarryOut,
    output logic             Overflow
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           ovf_add;
    logic           ovf_sub;

    assign sum     = {1'b0, A} + {1'b0, B};
    assign diff    = {1'b0, A} - {1'b0, B};
    assign ovf_add = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign ovf_sub = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

    // Opcode decode and flag generation.
    always_comb begin
        Result   = '0;
        CarryOut = 1'b0;
        Overflow = 1'b0;
        case (ALUop)
            3'b000: Result = A & B;
            3'b001: Result = A | B;
            3'b010: begin
                Result   = sum[WIDTH-1:0];
                CarryOut = sum[WIDTH];
                Overflow = ovf_add;
            end
            3'b110: begin
                Result   = diff[WIDTH-1:0];
                CarryOut = diff[WIDTH];
                Overflow = ovf_sub;
            end
            3'b111: Result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);
endmodule

module alu_issue_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_issue_stage_if.slave     bus,
    input  logic                 clr_sticky,
    output logic [CNT_WIDTH-1:0] op_count,
    output logic                 sticky_ovf,
    output logic                 sticky_cout
);
    typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  load_out;
    logic                  load_skid;
    logic                  in_fire;
    logic                  out_fire;

    logic [DATA_WIDTH-1:0] skid_a;
    logic [DATA_WIDTH-1:0] skid_b;
    logic [2:0]            skid_op;

    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [2:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_cout;
    logic                  alu_ovf;
    logic                  alu_illegal;

    logic [DATA_WIDTH-1:0] out_result_q;
    logic                  out_zero_q;
    logic                  out_cout_q;
    logic                  out_ovf_q;
    logic                  out_illegal_q;

    assign bus.in_ready  = (state != ST_FULL);
    assign bus.out_valid = (state != ST_EMPTY);
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    // The skid entry is older than anything on the input, so it has priority.
    assign alu_a  = (state == ST_FULL) ? skid_a  : bus.in_A;
    assign alu_b  = (state == ST_FULL) ? skid_b  : bus.in_B;
    assign alu_op = (state == ST_FULL) ? skid_op : bus.in_ALUop;
    assign alu_illegal = (alu_op == 3'b011) || (alu_op == 3'b100) || (alu_op == 3'b101);

    alu #(.WIDTH(DATA_WIDTH)) u_alu (
        .A        (alu_a),
        .B        (alu_b),
        .ALUop    (alu_op),
        .Result   (alu_result),
        .Zero     (alu_zero),
        .CarryOut (alu_cout),
        .Overflow (alu_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_EMPTY;
        else      state <= state_nxt;
    end

    // Next state plus load strobes for the output register and the skid entry.
    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    load_out  = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = ST_FULL;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    load_out  = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Skid entry holds raw operands; the ALU evaluates them when they drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_a  <= '0;
            skid_b  <= '0;
            skid_op <= 3'b000;
        end else if (load_skid) begin
            skid_a  <= bus.in_A;
            skid_b  <= bus.in_B;
            skid_op <= bus.in_ALUop;
        end
    end

    // Output register; illegal opcodes still produce an entry, with data and flags zeroed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
            out_cout_q    <= 1'b0;
            out_ovf_q     <= 1'b0;
            out_illegal_q <= 1'b0;
        end else if (load_out) begin
            out_result_q  <= alu_illegal ? '0 : alu_result;
            out_zero_q    <= alu_zero && !alu_illegal;
            out_cout_q    <= alu_cout && !alu_illegal;
            out_ovf_q     <= alu_ovf && !alu_illegal;
            out_illegal_q <= alu_illegal;
        end
    end

    assign bus.out_Result   = out_result_q;
    assign bus.out_Zero     = out_zero_q;
    assign bus.out_CarryOut = out_cout_q;
    assign bus.out_Overflow = out_ovf_q;
    assign bus.out_illegal  = out_illegal_q;

    // Delivered-result counter, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          op_count <= '0;
        else if (out_fire) op_count <= op_count + CNT_WIDTH'(1);
    end

`ifdef ALU_STICKY_FLAGS_EN
    // Sticky flags accumulate over delivered results; a new set beats a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_ovf  <= 1'b0;
            sticky_cout <= 1'b0;
        end else begin
            if (out_fire && out_ovf_q)  sticky_ovf <= 1'b1;
            else if (clr_sticky)        sticky_ovf <= 1'b0;
            if (out_fire && out_cout_q) sticky_cout <= 1'b1;
            else if (clr_sticky)        sticky_cout <= 1'b0;
        end
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_ovf        = 1'b0;
    assign sticky_cout       = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_sticky = 1'b0;
    logic [15:0] op_count;
    logic        sticky_ovf;
    logic        sticky_cout;
    int          checks = 0;
    int          errors = 0;

    alu_issue_stage_if #(.DATA_WIDTH(32)) bus ();

    alu_issue_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clr_sticky  (clr_sticky),
        .op_count    (op_count),
        .sticky_ovf  (sticky_ovf),
        .sticky_cout (sticky_cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.in_valid = v;
        bus.in_A     = a;
        bus.in_B     = b;
        bus.in_ALUop = op;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        bus.out_ready = 1'b0;
        #12;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_Result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.out_Result); end
        checks++; if ({bus.out_Zero, bus.out_CarryOut, bus.out_Overflow, bus.out_illegal} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {bus.out_Zero, bus.out_CarryOut, bus.out_Overflow, bus.out_illegal}); end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got %0d exp 0", op_count); end
        checks++; if ({sticky_ovf, sticky_cout} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b exp 00", {sticky_ovf, sticky_cout}); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_overflow();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h7FFF_FFFF, 32'h1, 3'b010);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_Result !== 32'h8000_0000) begin errors++; $display("FAIL add_result got %h exp 80000000", bus.out_Result); end
        checks++; if ({bus.out_Zero, bus.out_CarryOut, bus.out_Overflow} !== 3'b001) begin errors++; $display("FAIL add_flags zco got %b exp 001", {bus.out_Zero, bus.out_CarryOut, bus.out_Overflow}); end
        tick();
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL add_op_count got %0d exp 1", op_count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drained got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd5, 3'b110);
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready0 got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_Result !== 32'h0 || bus.out_Zero !== 1'b1) begin errors++; $display("FAIL b2b_sub got %h z=%b exp 0 z=1", bus.out_Result, bus.out_Zero); end
        drive(1'b1, 32'd3, 32'd7, 3'b111);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready1 got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_Result !== 32'h1 || bus.out_Zero !== 1'b0) begin errors++; $display("FAIL b2b_slt got v=%b %h z=%b exp v=1 1 z=0", bus.out_valid, bus.out_Result, bus.out_Zero); end
        tick();
        checks++; if (op_count !== 16'd3) begin errors++; $display("FAIL b2b_op_count got %0d exp 3", op_count); end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd1, 3'b010);
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_busy got %b exp 1", bus.in_ready); end
        drive(1'b1, 32'd2, 32'd2, 3'b010);
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_full got %b exp 0", bus.in_ready); end
        checks++; if (bus.out_Result !== 32'd2) begin errors++; $display("FAIL stall_first got %0d exp 2", bus.out_Result); end
        drive(1'b1, 32'd3, 32'd3, 3'b010);
        tick();
        checks++; if (bus.in_ready !== 1'b0 || bus.out_Result !== 32'd2) begin errors++; $display("FAIL stall_hold got rdy=%b %0d exp rdy=0 2", bus.in_ready, bus.out_Result); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_Result !== 32'd4 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_skid got %0d rdy=%b exp 4 rdy=1", bus.out_Result, bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        checks++; if (bus.out_Result !== 32'd6 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_third got %0d v=%b exp 6 v=1", bus.out_Result, bus.out_valid); end
        tick();
        checks++; if (op_count !== 16'd6 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_op_count got %0d v=%b exp 6 v=0", op_count, bus.out_valid); end
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'hFF, 32'h1, 3'b011);
        tick();
        checks++; if (bus.out_illegal !== 1'b1 || bus.out_Result !== 32'h0) begin errors++; $display("FAIL illegal_out got ill=%b %h exp ill=1 0", bus.out_illegal, bus.out_Result); end
        checks++; if ({bus.out_Zero, bus.out_CarryOut, bus.out_Overflow} !== 3'b000) begin errors++; $display("FAIL illegal_flags got %b exp 000", {bus.out_Zero, bus.out_CarryOut, bus.out_Overflow}); end
        drive(1'b1, 32'hFF, 32'h0F, 3'b000);
        tick();
        checks++; if (bus.out_illegal !== 1'b0 || bus.out_Result !== 32'h0F) begin errors++; $display("FAIL and_out got ill=%b %h exp ill=0 0f", bus.out_illegal, bus.out_Result); end
        drive(1'b1, 32'hF0, 32'h0F, 3'b001);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        checks++; if (bus.out_Result !== 32'hFF) begin errors++; $display("FAIL or_out got %h exp ff", bus.out_Result); end
        tick();
        checks++; if (op_count !== 16'd9) begin errors++; $display("FAIL illegal_op_count got %0d exp 9", op_count); end
    endtask

    task automatic test_reset_full();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd10, 32'd1, 3'b010);
        tick();
        drive(1'b1, 32'd20, 32'd1, 3'b010);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstfull_full got %b exp 0", bus.in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || op_count !== 16'd0) begin errors++; $display("FAIL rstfull_async got v=%b rdy=%b cnt=%0d exp 0 1 0", bus.out_valid, bus.in_ready, op_count); end
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0 || op_count !== 16'd0) begin errors++; $display("FAIL rstfull_stale got v=%b cnt=%0d exp 0 0", bus.out_valid, op_count); end
    endtask

    task automatic test_sticky();
        logic exp_set;
`ifdef ALU_STICKY_FLAGS_EN
        exp_set = 1'b1;
`else
        exp_set = 1'b0;
`endif
        bus.out_ready = 1'b1;
        drive(1'b1, 32'd0, 32'd1, 3'b110);
        tick();
        checks++; if (bus.out_CarryOut !== 1'b1 || bus.out_Result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_borrow got c=%b %h exp c=1 ffffffff", bus.out_CarryOut, bus.out_Result); end
        drive(1'b1, 32'd1, 32'd1, 3'b000);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        checks++; if (sticky_cout !== exp_set || sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_set got c=%b o=%b exp c=%b o=0", sticky_cout, sticky_ovf, exp_set); end
        tick();
        checks++; if (sticky_cout !== exp_set) begin errors++; $display("FAIL sticky_hold got %b exp %b", sticky_cout, exp_set); end
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        checks++; if (sticky_cout !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b exp 0", sticky_cout); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_reset_full();
        test_sticky();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered execute stage wrapping one `alu` instance with valid/ready handshakes on both sides. Accepts operand/opcode tuples from decode and presents registered `Result`, `Zero`, `CarryOut` and `Overflow` to writeback. Sustains one operation per cycle and absorbs one cycle of downstream stall through a single-entry operand skid buffer.

## Interface
- `DATA_WIDTH`, 32, operand/result width; passed to `alu`.
- `CNT_WIDTH`, 16, width of the delivered-operation counter.

- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream tuple valid.
- `in_ready`  out  1  stage can accept.
- `in_A`, `in_B`  in  DATA_WIDTH  operands.
- `in_ALUop`  in  3  AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- `out_valid`  out  1  result register valid.
- `out_ready`  in  1  downstream accepts.
- `out_Result`  out  DATA_WIDTH  registered ALU result.
- `out_Zero`, `out_CarryOut`, `out_Overflow`  out  1 each  registered ALU flags.
- `out_illegal`  out  1  opcode was 011/100/101.
- `op_count`  out  CNT_WIDTH  results delivered since reset.
- `clr_sticky`  in  1  clears sticky flags.
- `sticky_ovf`, `sticky_cout`  out  1 each  sticky flags (see Configuration).

## Operation
- Fires: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Storage: output register (OUT) plus one skid entry (SKID) holding raw A/B/ALUop.
- The single `alu` instance takes SKID operands when SKID is valid, else `in_*`.
- States: EMPTY (OUT invalid), BUSY (OUT valid, SKID empty), FULL (OUT and SKID valid).
- `in_ready = (state != FULL)`, decoded from state only and never from `out_ready`.
- EMPTY: `in_fire` → load OUT from ALU(in) → BUSY.
- BUSY, `in_fire & out_fire` → reload OUT from ALU(in), stay BUSY.
- BUSY, `in_fire & !out_ready` → capture `in_*` into SKID → FULL.
- BUSY, `out_fire & !in_fire` → EMPTY.
- FULL: `out_fire` → load OUT from ALU(SKID), clear SKID → BUSY. No input accepted in FULL.
- Illegal opcode: tuple still flows in order. OUT gets `out_Result = 0`, all flags 0, `out_illegal = 1`.
- `op_count` increments on every `out_fire`, illegal results included. Wraps from all-ones to 0.
- Ordering: results leave strictly in acceptance order. No drops, no duplicates.
- OUT fields hold stable while `out_valid & !out_ready`.

## Timing
- Reset (async assert, deassert synchronous to `clk`): state EMPTY, `in_ready` = 1, `out_valid` = 0, all `out_*` data/flags = 0, `out_illegal` = 0, `op_count` = 0, sticky flags = 0, SKID invalid.
- Reset mid-operation: OUT and SKID contents are discarded. No result is emitted for them.
- Latency: `in_fire` at edge N → `out_valid` = 1 after edge N (visible in cycle N+1) when the stage is EMPTY or draining.
- Throughput: 1 result/cycle with `out_ready` held high.
- Stall: the first stalled cycle captures at most one extra tuple. `in_ready` falls the cycle after the SKID capture.
- FULL with `out_ready` = 1: SKID result appears in OUT the next cycle, and `in_ready` returns to 1 in that cycle.

## Configuration
- `ALU_STICKY_FLAGS_EN` defined:
  - `sticky_ovf` sets on any `out_fire` with `out_Overflow` = 1.
  - `sticky_cout` sets on any `out_fire` with `out_CarryOut` = 1.
  - Both clear when `clr_sticky` = 1. Set wins over clear in the same cycle.
- `ALU_STICKY_FLAGS_EN` undefined: `sticky_ovf` and `sticky_cout` are constant 0, `clr_sticky` is ignored, and no sticky registers are synthesised.

## Test plan
- ADD A=0x7FFFFFFF, B=1, `out_ready`=1 → next cycle `out_Result`=0x80000000, `out_Overflow`=1, `out_CarryOut`=0, `out_Zero`=0, `op_count`=1.
- SUB A=5, B=5, then SLT A=3, B=7 back-to-back → Result=0 with `out_Zero`=1, then Result=1. One result per cycle, `in_ready` stays 1.
- `out_ready`=0 with 3 ADD tuples offered (1+1, 2+2, 3+3) → first two accepted, `in_ready`=0 with state FULL. After releasing `out_ready`: outputs 2, 4, 6 in order, `op_count`=3.
- ALUop=3'b011, A=0xFF, B=0x1 → `out_illegal`=1, `out_Result`=0, flags 0, `op_count` increments.
- Reset pulled low while FULL → immediately `out_valid`=0 and `in_ready`=1 after release, `op_count`=0, no stale result emitted.
- With `ALU_STICKY_FLAGS_EN`: SUB 0−1 (CarryOut=1), then AND → `sticky_cout` stays 1. Pulse `clr_sticky` → 0. Without the macro → `sticky_cout` is always 0.
